ahb_sram_slave: RTL and testbench

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

---
 rtl/ahb_sram_slave_if.sv | 27 ++
 rtl/ahb_sram_slave.sv | 126 ++++++++++++
 tb/tb_ahb_sram_slave.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_slave_if.sv
// rtl/ahb_sram_slave_if.sv - AHB-Lite bus bundle between a master/interconnect and ahb_sram_slave
interface ahb_sram_slave_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  logic              hsel;
  logic [W_ADDR-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [W_DATA-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic [1:0]        hresp;
  logic [W_DATA-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite SRAM slave with two-cycle ERROR; AHB_SRAM_WAIT_EN enables wait states
module ahb_sram_slave #(
  parameter int W_ADDR    = 32,
  parameter int W_DATA    = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int WAIT_CYC  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  ahb_sram_slave_if.slave ahb
);
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int NBYTES = W_DATA / 8;
  localparam logic [W_ADDR-1:0] DEPTH_W = W_ADDR'(MEM_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t state, state_nxt, go_state;

  logic [31:0]   mem [MEM_DEPTH];
  logic [AW-1:0] reg_idx;
  logic [1:0]    reg_lo;
  logic [2:0]    reg_size;
  logic          reg_write;
  logic          ready_int, accept, legal, misalign, wait_done;
  logic [3:0]    be;
  logic          unused_bits;

  assign unused_bits = ^{ahb.hburst, ahb.htrans[0]};

  // Only IDLE, DATA and ERR2 drive hreadyout high, so only they can take a new address phase.
  assign ready_int = (state != S_WAIT) && (state != S_ERR1);
  assign accept    = ahb.hsel && ahb.hready && ahb.htrans[1] && ready_int;

  always_comb begin
    misalign = 1'b0;
    case (ahb.hsize)
      3'd1:    misalign = ahb.haddr[0];
      3'd2:    misalign = |ahb.haddr[1:0];
      default: misalign = 1'b0;
    endcase
  end

  assign legal = (ahb.hsize <= 3'd2) && !misalign
              && ({2'b00, ahb.haddr[W_ADDR-1:2]} < DEPTH_W);

`ifdef AHB_SRAM_WAIT_EN
  localparam logic [3:0] WAIT_N = 4'(WAIT_CYC);
  logic [3:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wait_cnt <= 4'd0;
    else if (accept && legal)    wait_cnt <= WAIT_N;
    else if (state == S_WAIT)    wait_cnt <= wait_cnt - 4'd1;
  end

  assign wait_done = (wait_cnt == 4'd1);
  assign go_state  = (WAIT_N != 4'd0) ? S_WAIT : S_DATA;
`else
  logic [3:0] unused_wait;
  assign unused_wait = 4'(WAIT_CYC);
  assign wait_done   = 1'b1;
  assign go_state    = S_DATA;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    ahb.hreadyout = 1'b1;
    ahb.hresp     = 2'b00;
    ahb.hrdata    = '0;
    case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (accept) state_nxt = legal ? go_state : S_ERR1;
        else        state_nxt = S_IDLE;
        if (state == S_ERR2) ahb.hresp = 2'b01;
        if (state == S_DATA && !reg_write) ahb.hrdata = mem[reg_idx];
      end
      S_WAIT: begin
        ahb.hreadyout = 1'b0;
        if (wait_done) state_nxt = S_DATA;
      end
      S_ERR1: begin
        ahb.hreadyout = 1'b0;
        ahb.hresp     = 2'b01;
        state_nxt     = S_ERR2;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_idx   <= '0;
      reg_lo    <= 2'd0;
      reg_size  <= 3'd0;
      reg_write <= 1'b0;
    end else if (accept) begin
      reg_idx   <= ahb.haddr[AW+1:2];
      reg_lo    <= ahb.haddr[1:0];
      reg_size  <= ahb.hsize;
      reg_write <= ahb.hwrite;
    end
  end

  always_comb begin
    case (reg_size)
      3'd0:    be = 4'b0001 << reg_lo;
      3'd1:    be = reg_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Memory has no reset; the rst_n term keeps an aborted transfer from committing.
  always_ff @(posedge clk) begin
    if (rst_n && state == S_DATA && reg_write) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (be[b]) mem[reg_idx][8*b +: 8] <= ahb.hwdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - randomized self-checking bench for ahb_sram_slave against a word-array model
module tb_ahb_sram_slave;
  localparam int DEPTH = 1024;
`ifdef AHB_SRAM_WAIT_EN
  localparam int WAITS = 2;
`else
  localparam int WAITS = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ahb_sram_slave_if bus();
  ahb_sram_slave dut (.clk(clk), .rst_n(rst_n), .ahb(bus));

  // Single-slave system: bus HREADY is the slave's own HREADYOUT.
  assign bus.hready = bus.hreadyout;

  typedef struct {
    bit        sel;
    bit [1:0]  trans;
    bit [31:0] addr;
    bit        wr;
    bit [2:0]  size;
    bit [31:0] wdata;
  } xfer_t;

  xfer_t     q[$];
  bit [31:0] mdl [DEPTH];
  bit [31:0] last_rdata;
  int        n_vec = 0;
  int        n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input bit [31:0] addr, input bit wr, input bit [2:0] size,
                      input bit [31:0] wdata, input bit [1:0] trans = 2'b10, input bit sel = 1'b1);
    xfer_t x;
    x.sel = sel; x.trans = trans; x.addr = addr; x.wr = wr; x.size = size; x.wdata = wdata;
    q.push_back(x);
  endtask

  task automatic drive_addr(input xfer_t x);
    bus.hsel   = x.sel;
    bus.haddr  = x.addr;
    bus.htrans = x.trans;
    bus.hwrite = x.wr;
    bus.hsize  = x.size;
    bus.hburst = 3'($urandom);
  endtask

  task automatic drive_idle();
    bus.hsel   = 1'b0;
    bus.haddr  = $urandom;
    bus.htrans = 2'b00;
    bus.hwrite = 1'b0;
    bus.hsize  = 3'd0;
    bus.hburst = 3'd0;
  endtask

  function automatic bit active(input xfer_t x);
    return x.sel && x.trans[1];
  endfunction

  function automatic bit legal(input xfer_t x);
    if (x.size > 3'd2) return 1'b0;
    if (x.size == 3'd1 && x.addr[0]) return 1'b0;
    if (x.size == 3'd2 && x.addr[1:0] != 2'd0) return 1'b0;
    return (x.addr >> 2) < DEPTH;
  endfunction

  function automatic bit [31:0] merge(input bit [31:0] old, input xfer_t x);
    bit [31:0] r;
    int nb, lane0;
    r = old;
    nb = 1 << x.size;
    lane0 = int'(x.addr[1:0]);
    for (int k = 0; k < nb; k++) r[8*(lane0+k) +: 8] = x.wdata[8*(lane0+k) +: 8];
    return r;
  endfunction

  // Plays the queue as a pipelined master: address of item i+1 overlaps the data phase of item i.
  task automatic run_queue();
    int n;
    bit ok;
    n = q.size();
    if (n == 0) return;
    drive_addr(q[0]);
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      ok = (bus.hreadyout === 1'b1);
    end
    if (!ok) check_val("start_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      xfer_t x;
      bit act, lgl, done;
      int lows, exp_lows, idx;
      bit [31:0] exp_rd;
      bit [1:0] exp_resp;
      x = q[i];
      act = active(x);
      lgl = legal(x);
      idx = (act && lgl) ? int'(x.addr >> 2) : 0;
      bus.hwdata = x.wdata;
      if (i + 1 < n) drive_addr(q[i+1]);
      else           drive_idle();
      exp_lows = !act ? 0 : (lgl ? WAITS : 1);
      exp_resp = (act && !lgl) ? 2'b01 : 2'b00;
      exp_rd   = (act && lgl && !x.wr) ? mdl[idx] : 32'h0;
      lows = 0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(negedge clk);
        if (bus.hreadyout !== 1'b1) begin
          lows++;
          check_val("wait_resp", bus.hresp, exp_resp);
          check_val("wait_rdata", bus.hrdata, 32'h0);
        end else begin
          check_val("resp", bus.hresp, exp_resp);
          check_val("rdata", bus.hrdata, exp_rd);
          if (act && lgl && !x.wr) last_rdata = bus.hrdata;
          done = 1'b1;
        end
      end
      if (!done) check_val("data_timeout", 32'd0, 32'd1);
      check_val("wait_cycles", lows, exp_lows);
      @(posedge clk); #1;
      if (act && lgl && x.wr) mdl[idx] = merge(mdl[idx], x);
    end
    q.delete();
  endtask

  initial begin
    xfer_t w;
    rst_n = 1'b0;
    bus.hwdata = 32'h0;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_hreadyout", bus.hreadyout, 32'd1);
    check_val("reset_hresp", bus.hresp, 32'd0);
    check_val("reset_hrdata", bus.hrdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < DEPTH; i++) push(32'(i * 4), 1'b1, 3'd2, $urandom);
    run_queue();

    push(32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
    push(32'h10, 1'b0, 3'd2, 32'h0);
    run_queue();
    check_val("word_rw", last_rdata, 32'hDEADBEEF);

    push(32'h10, 1'b1, 3'd2, 32'h11223344);
    push(32'h13, 1'b1, 3'd0, 32'hAB000000);
    push(32'h10, 1'b0, 3'd2, 32'h0);
    run_queue();
    check_val("byte_lane", last_rdata, 32'hAB223344);

    push(32'h1000, 1'b1, 3'd2, 32'h12345678);
    push(32'h3101, 1'b0, 3'b101, 32'h0);
    push(32'h02, 1'b1, 3'd2, 32'hFFFFFFFF);
    push(32'h00, 1'b0, 3'd2, 32'h0);
    run_queue();

    push(32'h20, 1'b1, 3'd2, 32'hA0A0A0A1, 2'b10);
    push(32'h24, 1'b1, 3'd2, 32'hB0B0B0B2, 2'b11);
    push(32'h28, 1'b1, 3'd2, 32'hC0C0C0C3, 2'b11);
    push(32'h2C, 1'b1, 3'd2, 32'hD0D0D0D4, 2'b11);
    push(32'h2C, 1'b0, 3'd2, 32'h0);
    run_queue();
    check_val("burst_raw", last_rdata, 32'hD0D0D0D4);
    push(32'h20, 1'b0, 3'd2, 32'h0);
    push(32'h24, 1'b0, 3'd2, 32'h0);
    push(32'h28, 1'b0, 3'd2, 32'h0);
    run_queue();
    check_val("burst_beat3", last_rdata, 32'hC0C0C0C3);

    push(32'h10, 1'b1, 3'd2, 32'h0BAD0BAD, 2'b00);
    push(32'h10, 1'b1, 3'd2, 32'h0BAD0BAD, 2'b01);
    push(32'h10, 1'b1, 3'd2, 32'h0BAD0BAD, 2'b10, 1'b0);
    push(32'h10, 1'b0, 3'd2, 32'h0);
    run_queue();
    check_val("idle_no_write", last_rdata, 32'hAB223344);

    for (int i = 0; i < 400; i++) begin
      int r;
      bit [31:0] a;
      bit [2:0] sz;
      bit [1:0] tr;
      bit sel;
      r   = $urandom_range(0, 99);
      a   = 32'($urandom_range(0, 63));
      sz  = 3'($urandom_range(0, 2));
      tr  = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
      sel = 1'b1;
      if (r < 6) a = a + 32'h1000;
      else if (r < 12) sz = 3'($urandom_range(3, 7));
      else if (r < 16) tr = 2'($urandom_range(0, 1));
      else if (r < 20) sel = 1'b0;
      if (r >= 20 && r < 85) a = a & ~((32'd1 << sz) - 32'd1);
      push(a, 1'($urandom_range(0, 1)), sz, $urandom, tr, sel);
    end
    run_queue();

    w.sel = 1'b1; w.trans = 2'b10; w.addr = 32'h40; w.wr = 1'b1; w.size = 3'd2; w.wdata = ~mdl[16];
    drive_addr(w);
    @(posedge clk); #1;
    bus.hwdata = w.wdata;
    drive_idle();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("abort_hreadyout", bus.hreadyout, 32'd1);
    check_val("abort_hresp", bus.hresp, 32'd0);
    check_val("abort_hrdata", bus.hrdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(32'h40, 1'b0, 3'd2, 32'h0);
    run_queue();
    check_val("abort_no_write", last_rdata, mdl[16]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
